// File: rtl/fetch_queue_pkg.sv
// Shared constants and payload types for the fetch-to-decode instruction queue.
package fetch_queue_pkg;

  localparam int unsigned BIN_DIG  = 32;
  localparam int unsigned FQ_PC_W  = 32;
  localparam int unsigned FQ_DEPTH = 4;

  typedef struct packed {
    logic [FQ_PC_W-1:0] pc;
    logic [BIN_DIG-1:0] inst;
  } fq_entry_t;

endpackage

// File: rtl/fetch_queue_if.sv
// Fetch/decode handshake bundle; slave is the queue, master is the fetch+decode side.
interface fetch_queue_if #(
  parameter int unsigned DEPTH  = fetch_queue_pkg::FQ_DEPTH,
  parameter int unsigned INST_W = fetch_queue_pkg::BIN_DIG,
  parameter int unsigned PC_W   = fetch_queue_pkg::FQ_PC_W
);

  localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

  logic              in_valid;
  logic              in_ready;
  logic [PC_W-1:0]   in_pc;
  logic [INST_W-1:0] in_inst;
  logic              flush;
  logic              out_valid;
  logic              out_ready;
  logic [PC_W-1:0]   out_pc;
  logic [INST_W-1:0] out_inst;
  logic [CNT_W-1:0]  count;

  modport slave (
    input  in_valid, in_pc, in_inst, flush, out_ready,
    output in_ready, out_valid, out_pc, out_inst, count
  );

  modport master (
    output in_valid, in_pc, in_inst, flush, out_ready,
    input  in_ready, out_valid, out_pc, out_inst, count
  );

endinterface

// File: rtl/fq_mem.sv
// Entry storage: one synchronous write port, one asynchronous read port, no reset.
module fq_mem
  import fetch_queue_pkg::*;
#(
  parameter int unsigned DEPTH = FQ_DEPTH,
  localparam int unsigned AW   = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  fq_entry_t     wdata,
  input  logic [AW-1:0] raddr,
  output fq_entry_t     rdata
);

  fq_entry_t mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/fetch_queue.sv
// In-order instruction buffer between fetch and decode with flush on redirect.
module fetch_queue
  import fetch_queue_pkg::*;
#(
  parameter int unsigned DEPTH  = FQ_DEPTH,
  parameter int unsigned INST_W = BIN_DIG,
  parameter int unsigned PC_W   = FQ_PC_W
) (
  input  logic          clk,
  input  logic          rst,
  fetch_queue_if.slave  q
);

  localparam int unsigned AW    = $clog2(DEPTH);
  localparam int unsigned CNT_W = AW + 1;

  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CNT_W-1:0] cnt;
  logic             empty;
  logic             full;
  logic             push;
  logic             pop;
  fq_entry_t        wdata;
  fq_entry_t        rdata;

  // Handshake qualifiers depend only on registered state, flush and rst, never on the far side.
  assign empty       = (cnt == '0);
  assign full        = (cnt == CNT_W'(DEPTH));
  assign q.in_ready  = !full  && !q.flush && !rst;
  assign q.out_valid = !empty && !q.flush && !rst;
  assign push        = q.in_valid  && q.in_ready;
  assign pop         = q.out_valid && q.out_ready;

  always_ff @(posedge clk) begin
    if (rst || q.flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   cnt <= cnt + CNT_W'(1);
        2'b01:   cnt <= cnt - CNT_W'(1);
        default: cnt <= cnt;
      endcase
    end
  end

  assign wdata.pc   = FQ_PC_W'(q.in_pc);
  assign wdata.inst = BIN_DIG'(q.in_inst);

  fq_mem #(.DEPTH(DEPTH)) u_mem (
    .clk   (clk),
    .we    (push),
    .waddr (wr_ptr),
    .wdata (wdata),
    .raddr (rd_ptr),
    .rdata (rdata)
  );

  // Head is forced to zero whenever it is not presentable.
  assign q.out_pc   = q.out_valid ? PC_W'(rdata.pc)     : '0;
  assign q.out_inst = q.out_valid ? INST_W'(rdata.inst) : '0;
  assign q.count    = cnt;

endmodule

// File: tb/tb_fetch_queue.sv
// Scenario and randomized checks of fetch_queue against a queue-based reference model.
module tb_fetch_queue;

  localparam int unsigned DEPTH = 4;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } ent_t;

  logic clk;
  logic rst;
  int   vectors;
  int   miscompares;
  ent_t mq[$];

  fetch_queue_if #(.DEPTH(DEPTH), .INST_W(32), .PC_W(32)) bus ();

  fetch_queue #(.DEPTH(DEPTH), .INST_W(32), .PC_W(32)) dut (
    .clk (clk),
    .rst (rst),
    .q   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic m_in_ready();
    return (mq.size() < DEPTH) && !bus.flush && !rst;
  endfunction

  function automatic logic m_out_valid();
    return (mq.size() > 0) && !bus.flush && !rst;
  endfunction

  function automatic logic [31:0] m_pc();
    return m_out_valid() ? mq[0].pc : 32'h0;
  endfunction

  function automatic logic [31:0] m_inst();
    return m_out_valid() ? mq[0].inst : 32'h0;
  endfunction

  // Apply inputs at the falling edge and let combinational outputs settle.
  task automatic drive(input logic r, input logic iv, input logic [31:0] pc,
                       input logic [31:0] inst, input logic fl, input logic ordy);
    rst           = r;
    bus.in_valid  = iv;
    bus.in_pc     = pc;
    bus.in_inst   = inst;
    bus.flush     = fl;
    bus.out_ready = ordy;
    #1;
  endtask

  // Advance one rising edge and update the reference model from the specification rules.
  task automatic tick();
    logic do_push, do_pop;
    ent_t e;
    do_push = bus.in_valid && m_in_ready();
    do_pop  = bus.out_ready && m_out_valid();
    e.pc    = bus.in_pc;
    e.inst  = bus.in_inst;
    @(posedge clk);
    if (rst || bus.flush) mq.delete();
    else begin
      if (do_pop) void'(mq.pop_front());
      if (do_push) mq.push_back(e);
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    for (int i = 0; i < 2; i++) begin
      drive(1'b1, 1'b1, $urandom, $urandom, 1'b0, 1'b1);
      vectors++;
      if (bus.in_ready !== 1'b0 || bus.out_valid !== 1'b0) begin
        miscompares++;
        $display("FAIL reset_handshake: in_ready=%b out_valid=%b, required 0/0", bus.in_ready, bus.out_valid);
      end
      vectors++;
      if (bus.out_pc !== 32'h0 || bus.out_inst !== 32'h0) begin
        miscompares++;
        $display("FAIL reset_head: pc=%h inst=%h, required 0/0", bus.out_pc, bus.out_inst);
      end
      tick();
    end
    drive(1'b0, 1'b1, 32'h0, 32'h00000013, 1'b0, 1'b0);
    vectors++;
    if (bus.count !== 3'd0 || bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL reset_state: count=%0d out_valid=%b in_ready=%b, required 0/0/1", bus.count, bus.out_valid, bus.in_ready);
    end
    tick();
    drive(1'b0, 1'b1, 32'h4, 32'h00500093, 1'b0, 1'b0);
    tick();
    drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    vectors++;
    if (bus.count !== 3'd2 || bus.out_valid !== 1'b1 || bus.out_pc !== 32'h0 || bus.out_inst !== 32'h00000013) begin
      miscompares++;
      $display("FAIL simple_fill: count=%0d valid=%b pc=%h inst=%h, required 2/1/00000000/00000013",
               bus.count, bus.out_valid, bus.out_pc, bus.out_inst);
    end
  endtask

  task automatic test_fill_full();
    logic [31:0] want;
    drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    tick();
    for (int i = 0; i < 5; i++) begin
      drive(1'b0, 1'b1, 32'(i * 4), 32'hA000_0000 + 32'(i), 1'b0, 1'b0);
      vectors++;
      if (bus.in_ready !== (i < 4)) begin
        miscompares++;
        $display("FAIL fill_in_ready[%0d]: got %b, required %b", i, bus.in_ready, (i < 4));
      end
      tick();
    end
    drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    vectors++;
    if (bus.count !== 3'd4 || bus.in_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL full_state: count=%0d in_ready=%b, required 4/0", bus.count, bus.in_ready);
    end
    for (int i = 0; i < 4; i++) begin
      drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b1);
      want = 32'(i * 4);
      vectors++;
      if (bus.out_valid !== 1'b1 || bus.out_pc !== want || bus.out_inst !== 32'hA000_0000 + 32'(i)) begin
        miscompares++;
        $display("FAIL drain[%0d]: valid=%b pc=%h inst=%h, required 1/%h/%h", i, bus.out_valid, bus.out_pc, bus.out_inst,
                 want, 32'hA000_0000 + 32'(i));
      end
      tick();
    end
    drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    vectors++;
    if (bus.out_valid !== 1'b0 || bus.count !== 3'd0) begin
      miscompares++;
      $display("FAIL drained_empty: valid=%b count=%0d, required 0/0", bus.out_valid, bus.count);
    end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 2; i++) begin
      drive(1'b0, 1'b1, 32'h200 + 32'(i * 4), $urandom, 1'b0, 1'b0);
      tick();
    end
    for (int i = 0; i < 10; i++) begin
      drive(1'b0, 1'b1, 32'h208 + 32'(i * 4), $urandom, 1'b0, 1'b1);
      vectors++;
      if (bus.count !== 3'd2 || bus.out_pc !== 32'h200 + 32'(i * 4) || bus.in_ready !== 1'b1) begin
        miscompares++;
        $display("FAIL b2b[%0d]: count=%0d pc=%h in_ready=%b, required 2/%h/1", i, bus.count, bus.out_pc, bus.in_ready,
                 32'h200 + 32'(i * 4));
      end
      tick();
    end
  endtask

  task automatic test_full_pop();
    while (mq.size() < DEPTH) begin
      drive(1'b0, 1'b1, 32'h300 + 32'(mq.size() * 4), $urandom, 1'b0, 1'b0);
      tick();
    end
    drive(1'b0, 1'b1, 32'hDEAD_0000, 32'hDEAD_BEEF, 1'b0, 1'b1);
    vectors++;
    if (bus.in_ready !== 1'b0 || bus.out_valid !== 1'b1 || bus.out_pc !== m_pc()) begin
      miscompares++;
      $display("FAIL full_pop_cycle: in_ready=%b valid=%b pc=%h, required 0/1/%h", bus.in_ready, bus.out_valid, bus.out_pc, m_pc());
    end
    tick();
    drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    vectors++;
    if (bus.in_ready !== 1'b1 || bus.count !== 3'd3 || bus.out_pc !== m_pc() || bus.out_inst !== m_inst()) begin
      miscompares++;
      $display("FAIL full_pop_after: in_ready=%b count=%0d pc=%h, required 1/3/%h", bus.in_ready, bus.count, bus.out_pc, m_pc());
    end
  endtask

  task automatic test_flush();
    drive(1'b0, 1'b1, 32'h400, $urandom, 1'b1, 1'b1);
    vectors++;
    if (bus.in_ready !== 1'b0 || bus.out_valid !== 1'b0 || bus.out_pc !== 32'h0) begin
      miscompares++;
      $display("FAIL flush_cycle: in_ready=%b valid=%b pc=%h, required 0/0/0", bus.in_ready, bus.out_valid, bus.out_pc);
    end
    tick();
    drive(1'b0, 1'b1, 32'h100, 32'h0000_0100, 1'b0, 1'b1);
    vectors++;
    if (bus.count !== 3'd0 || bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL flush_after: count=%0d valid=%b in_ready=%b, required 0/0/1", bus.count, bus.out_valid, bus.in_ready);
    end
    tick();
    drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b1);
    vectors++;
    if (bus.out_valid !== 1'b1 || bus.out_pc !== 32'h100 || bus.count !== 3'd1) begin
      miscompares++;
      $display("FAIL flush_then_push: valid=%b pc=%h count=%0d, required 1/00000100/1", bus.out_valid, bus.out_pc, bus.count);
    end
    tick();
    drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    vectors++;
    if (bus.out_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL flush_no_stale: valid=%b pc=%h, required 0", bus.out_valid, bus.out_pc);
    end
  endtask

  task automatic test_empty_pop();
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 1'b0, $urandom, $urandom, 1'b0, 1'b1);
      vectors++;
      if (bus.out_valid !== 1'b0 || bus.out_pc !== 32'h0 || bus.out_inst !== 32'h0 || bus.count !== 3'd0) begin
        miscompares++;
        $display("FAIL empty_pop[%0d]: valid=%b pc=%h inst=%h count=%0d, required 0/0/0/0", i, bus.out_valid, bus.out_pc,
                 bus.out_inst, bus.count);
      end
      tick();
    end
    drive(1'b0, 1'b1, 32'h500, 32'h1234_5678, 1'b0, 1'b1);
    vectors++;
    if (bus.out_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL no_bypass: valid=%b, required 0", bus.out_valid);
    end
    tick();
    drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b1);
    vectors++;
    if (bus.out_valid !== 1'b1 || bus.out_pc !== 32'h500 || bus.out_inst !== 32'h1234_5678) begin
      miscompares++;
      $display("FAIL empty_then_push: valid=%b pc=%h inst=%h, required 1/00000500/12345678", bus.out_valid, bus.out_pc, bus.out_inst);
    end
    tick();
  endtask

  task automatic test_random();
    logic [31:0] pc, inst;
    logic        iv, stalled;
    stalled = 1'b0;
    pc      = 32'h1000;
    inst    = $urandom;
    iv      = 1'b0;
    for (int i = 0; i < 400; i++) begin
      if (!stalled) begin
        iv   = ($urandom_range(0, 3) != 0);
        pc   = pc + 32'h4;
        inst = $urandom;
      end
      drive(($urandom_range(0, 49) == 0), iv, pc, inst, ($urandom_range(0, 19) == 0), ($urandom_range(0, 2) != 0));
      vectors++;
      if (bus.in_ready !== m_in_ready() || bus.out_valid !== m_out_valid() || bus.count !== 3'(mq.size())) begin
        miscompares++;
        $display("FAIL rand_ctrl[%0d]: in_ready=%b out_valid=%b count=%0d, required %b/%b/%0d", i, bus.in_ready,
                 bus.out_valid, bus.count, m_in_ready(), m_out_valid(), mq.size());
      end
      vectors++;
      if (bus.out_pc !== m_pc() || bus.out_inst !== m_inst()) begin
        miscompares++;
        $display("FAIL rand_head[%0d]: pc=%h inst=%h, required %h/%h", i, bus.out_pc, bus.out_inst, m_pc(), m_inst());
      end
      stalled = iv && !m_in_ready() && !bus.flush && !rst;
      tick();
    end
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    rst         = 1'b1;
    bus.in_valid  = 1'b0;
    bus.in_pc     = '0;
    bus.in_inst   = '0;
    bus.flush     = 1'b0;
    bus.out_ready = 1'b0;
    @(negedge clk);
    test_reset();
    test_fill_full();
    test_back_to_back();
    test_full_pop();
    test_flush();
    test_empty_pop();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
